icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch port and the memory controller's instruction port (iREN/iaddr/iload/iwait).
- Serves hits in the same cycle.
- On a miss, holds the fetch stage, requests one word from the memory controller, fills the frame, and then replays the lookup.
- The memory controller gives data-side requests priority, so the cache must tolerate an iwait stall of any length.

Parameters:
- SETS, 16, number of one-word frames; must be a power of 2, minimum 2.
- IDX_W, $clog2(SETS), index width; derived, never overridden.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  fetch request from the datapath.
- imemaddr  input  32  byte address of the fetch; bits [1:0] are ignored.
- ihit  output  1  fetch satisfied this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  read request to the memory controller.
- iaddr  output  32  word-aligned address to the memory controller.
- iload  input  32  data returned from the memory controller.
- iwait  input  1  memory controller stall; data is valid when low.

Behaviour:
- Address split: offset [1:0]; index [IDX_W+1:2]; tag [31:IDX_W+2], which is TAG_W = 30-IDX_W bits.
- Frame storage, per set: valid (1 bit), tag (TAG_W bits), data (32 bits).
  - Registers, no RAM macro.
- Reset (async, nRST low):
  - All valid bits cleared; state = IDLE; miss address register = 0.
  - Outputs while in reset: ihit=0, iREN=0, iaddr=0, imemload=0.
  - Tag and data arrays need not be reset.
- FSM states: IDLE and FETCH.
- IDLE:
  - ihit = imemREN & valid[idx] & (tag[idx]==addr tag), combinational, zero-latency.
  - imemload = data[idx] when ihit, else 0.
  - iREN=0, iaddr=0.
  - On imemREN & !hit: latch {imemaddr[31:2],2'b00} into missaddr and go to FETCH.
- FETCH:
  - iREN=1, iaddr=missaddr, ihit=0, imemload=0.
  - While iwait=1, stay in FETCH.
  - On iwait=0: write data=iload, the missaddr tag, and valid=1 into missaddr's index, then go to IDLE.
- Miss penalty: cycles spent in FETCH (memory latency) + 1 IDLE cycle, in which the refilled frame hits.
- Boundary conditions:
  - imemaddr changes or imemREN drops during FETCH: the fetch still completes to missaddr and the frame is filled; no abort.
  - Next IDLE cycle re-evaluates the current imemaddr; a second miss starts a new FETCH.
  - Conflict (same index, different tag): fill overwrites the frame unconditionally.
  - imemREN=0 in IDLE: ihit=0; no state change; no memory request.
  - Fill write and an IDLE lookup never overlap in the same cycle.
  - Reset asserted mid-FETCH: the fill is discarded, the cache returns to IDLE with every frame invalid, and iREN drops immediately (asynchronously).
- No self-modifying-code coherence; the data side never invalidates this cache.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count [31:0] and miss_count [31:0], both reset to 0.
  - hit_count increments on each IDLE cycle with ihit=1.
  - miss_count increments on each IDLE->FETCH transition.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Shared package icache_pkg, imported alongside cpu_types_pkg for word_t:
  - icache_state_t enum {IDLE, FETCH};
  - icache_frame_t struct {valid, tag, data};
  - addr-field helper typedef icache_addr_t packed {tag, idx, offset}, for SETS=16 by default.
- One sub-module, icache_frames: the register array with read index, write enable, write index, and write frame.
  - The FSM and hit logic stay in icache_direct.

Test Plan:
- Reset, then imemREN=1 at 0x00000040 with the memory model returning 0xDEADBEEF after 2 iwait cycles:
  - iREN=1 and iaddr=0x40 for 3 cycles;
  - ihit=1 and imemload=0xDEADBEEF on the next cycle;
  - a re-fetch of 0x40 hits the same cycle.
- Fill 0x40, then fetch 0x80 (same index 0, SETS=16):
  - miss, iaddr=0x80, fill;
  - a re-fetch of 0x40 misses again (conflict eviction).
- Start a miss at 0x100, then change imemaddr to 0x104 during FETCH:
  - iaddr stays 0x100 until iwait=0;
  - next cycle misses on 0x104;
  - a later fetch of 0x100 hits.
- iwait held high for 50 cycles during FETCH:
  - ihit=0 throughout; iREN stays 1; no fill until iwait=0.
- Assert nRST mid-FETCH:
  - iREN drops the same cycle;
  - after release, a fetch of a previously filled address misses.
- With ICACHE_STATS_EN:
  - Stimulus: 3 misses to distinct addresses, then 5 hits.
  - Response: miss_count=3, hit_count=5.
  - Force hit_count to 0xFFFFFFFF and apply one more hit: the counter stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Types and helpers shared by the direct-mapped instruction cache.
package icache_pkg;
  import cpu_types_pkg::*;

  localparam int DEF_SETS  = 16;
  localparam int DEF_IDX_W = $clog2(DEF_SETS);
  localparam int DEF_TAG_W = 30 - DEF_IDX_W;
  // Widest tag any legal SETS (>= 2) can need; narrower tags are zero-extended.
  localparam int TAG_W_MAX = 29;

  typedef enum logic {IDLE, FETCH} icache_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    word_t                data;
  } icache_frame_t;

  // Address field view for the default geometry.
  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_IDX_W-1:0] idx;
    logic [1:0]           offset;
  } icache_addr_t;

  // Tag field of a byte address for a given index width, zero-extended.
  function automatic logic [TAG_W_MAX-1:0] tag_of(input word_t a, input int idx_w);
    return TAG_W_MAX'(a >> (idx_w + 2));
  endfunction
endpackage

// File: rtl/icache_frames.sv
// Frame register array: combinational read port, one synchronous write port.
module icache_frames
  import cpu_types_pkg::*;
  import icache_pkg::*;
#(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output icache_frame_t    rd_frame,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  icache_frame_t    wr_frame
);
  logic [SETS-1:0]      valid_q, valid_d;
  logic [TAG_W_MAX-1:0] tag_q  [SETS];
  word_t                data_q [SETS];

  // Next valid vector: set the written frame's bit on a fill.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = wr_frame.valid;
  end

  // Valid bits are the only reset state; clearing them empties the cache.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag/data payload, meaningless until its valid bit is set.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_frame.tag;
      data_q[wr_idx] <= wr_frame.data;
    end
  end

  assign rd_frame = '{valid: valid_q[rd_idx], tag: tag_q[rd_idx], data: data_q[rd_idx]};
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one word per frame.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_direct
  import cpu_types_pkg::*;
  import icache_pkg::*;
#(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic [31:0] iload,
  input  logic        iwait
);
  icache_state_t state_q, state_d;
  word_t         missaddr_q, missaddr_d;
  logic          iren_q, iren_d;
  icache_frame_t rd_frame, wr_frame;
  logic          hit, fill;

  icache_frames #(.SETS(SETS)) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx   (imemaddr[IDX_W+1:2]),
    .rd_frame (rd_frame),
    .wr_en    (fill),
    .wr_idx   (missaddr_q[IDX_W+1:2]),
    .wr_frame (wr_frame)
  );

  assign hit  = (state_q == IDLE) & imemREN & rd_frame.valid &
                (rd_frame.tag == tag_of(imemaddr, IDX_W));
  // FETCH only ever fills missaddr, even if the fetch port moved on.
  assign fill = (state_q == FETCH) & ~iwait;
  assign wr_frame = '{valid: 1'b1, tag: tag_of(missaddr_q, IDX_W), data: iload};

  assign ihit     = hit;
  assign imemload = hit ? rd_frame.data : '0;
  assign iREN     = iren_q;
  assign iaddr    = iren_q ? missaddr_q : '0;

  // Miss FSM: IDLE looks up, FETCH waits out iwait then fills and replays.
  always_comb begin
    state_d    = state_q;
    missaddr_d = missaddr_q;
    iren_d     = iren_q;
    case (state_q)
      IDLE: if (imemREN && !hit) begin
        missaddr_d = {imemaddr[31:2], 2'b00};
        state_d    = FETCH;
        iren_d     = 1'b1;
      end
      FETCH: if (!iwait) begin
        state_d = IDLE;
        iren_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered memory request; reset drops iREN at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      missaddr_q <= '0;
      iren_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      missaddr_q <= missaddr_d;
      iren_q     <= iren_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating event counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == IDLE && state_d == FETCH && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule
